// File: rtl/inst_fetch_unit_pkg.sv
// Shared types for the instruction fetch front end: memory response word,
// buffered fetch entry and fetch FSM states.
package System_Pkg;

  typedef struct packed {
    logic [31:0] Data;
  } Mem_Respond;

  typedef struct packed {
    Mem_Respond  inst;
    logic [31:0] pc;
  } Fetch_Entry;

  typedef enum logic {
    S_RUN,
    S_FLUSH
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch unit boundary: redirect input, instruction memory request/response
// channel and the decode-side instruction stream.
interface inst_fetch_unit_if;
  import System_Pkg::*;

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  Mem_Respond  mem_resp;
  logic        dec_valid;
  Mem_Respond  dec_inst;
  logic [31:0] dec_pc;
  logic        dec_ready;

  modport master (
    input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp, dec_ready,
    output mem_req_valid, mem_req_addr, dec_valid, dec_inst, dec_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp, dec_ready,
    input  mem_req_valid, mem_req_addr, dec_valid, dec_inst, dec_pc
  );

endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// Generic synchronous FIFO with flush; head is read straight from the
// registered storage, so a push becomes visible one cycle later.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot for a push even when full.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetcher: issues sequential word requests under a credit limit,
// buffers in-order responses for decode and discards stale data on redirect.
module inst_fetch_unit
  import System_Pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input logic                clk,
  input logic                rst,
  inst_fetch_unit_if.master  fetch_if
);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] drop_cnt_q, drop_cnt_d;

  Fetch_Entry     fifo_in, fifo_head;
  logic [FCW-1:0] fifo_count;
  logic           fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;

  logic [31:0]    pcq_head;
  logic [OW-1:0]  pcq_count;
  logic           pcq_full, pcq_empty, pcq_push, pcq_pop;

  logic [31:0]    occupancy;
  logic           req_valid, req_fire, resp_fire;

  // Stale responses still pop the PC queue, so it stays paired with memory order.
  always_comb begin
    occupancy = 32'(fifo_count) + 32'(outstanding_q);
    req_valid = !rst && (state_q == S_RUN) && !fetch_if.redirect_valid &&
                (32'(outstanding_q) < 32'(MAX_OUTSTANDING)) &&
                (occupancy < 32'(FIFO_DEPTH));
    req_fire  = req_valid && fetch_if.mem_req_ready;
    resp_fire = fetch_if.mem_resp_valid && (outstanding_q != '0);

    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;
    fifo_flush    = 1'b0;
    pcq_push      = req_fire;
    pcq_pop       = resp_fire;
    fifo_in       = '{inst: fetch_if.mem_resp, pc: pcq_head};

    if (fetch_if.redirect_valid) begin
      pc_d          = fetch_if.redirect_pc & ~32'h3;
      fifo_flush    = 1'b1;
      outstanding_d = outstanding_q - OW'(resp_fire);
      drop_cnt_d    = outstanding_d;
      state_d       = (drop_cnt_d != '0) ? S_FLUSH : S_RUN;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      outstanding_d = outstanding_q + OW'(req_fire) - OW'(resp_fire);
      if (resp_fire) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - OW'(1);
        end else begin
          fifo_push = 1'b1;
        end
      end
      fifo_pop = !fifo_empty && fetch_if.dec_ready;
      if ((state_q == S_FLUSH) && (drop_cnt_d == '0)) begin
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RUN;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(Fetch_Entry)) u_inst_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  fetch_fifo #(.DEPTH(MAX_OUTSTANDING), .T(logic [31:0])) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (pcq_push),
    .push_data (pc_q),
    .pop       (pcq_pop),
    .head      (pcq_head),
    .count     (pcq_count),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

  assign fetch_if.mem_req_valid = req_valid;
  assign fetch_if.mem_req_addr  = pc_q;
  assign fetch_if.dec_valid     = !fifo_empty;
  assign fetch_if.dec_inst      = fifo_empty ? '0 : fifo_head.inst;
  assign fetch_if.dec_pc        = fifo_empty ? '0 : fifo_head.pc;

  a_resp_without_request: assert property (@(posedge clk) disable iff (rst)
    !(fetch_if.mem_resp_valid && (outstanding_q == '0)));
  a_pc_queue_tracks: assert property (@(posedge clk) disable iff (rst)
    (pcq_count == outstanding_q) && !(pcq_push && pcq_full && !pcq_pop) &&
    !(pcq_pop && pcq_empty));
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit: a queue-based memory and an
// epoch-tagged model of the expected request and decode streams.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          DEPTH      = 4;
  localparam int          MAX_OUT    = 2;
  localparam logic [31:0] DATA_KEY   = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  inst_fetch_unit_if fetch_if ();

  inst_fetch_unit #(
    .RESET_PC        (RESET_PC),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_if (fetch_if.master)
  );

  always #5 clk = ~clk;

  int          checks_done = 0;
  int          fail_count  = 0;
  pend_t       mem_q[$];
  int          cur_epoch   = 0;
  int          live        = 0;
  logic [31:0] exp_req_addr;
  logic [31:0] exp_dec_pc;
  bit          hold_chk    = 1'b0;
  logic [31:0] held_pc;
  logic [31:0] held_data;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks_done++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic driveIdle();
    fetch_if.redirect_valid = 1'b0;
    fetch_if.redirect_pc    = '0;
    fetch_if.mem_req_ready  = 1'b0;
    fetch_if.mem_resp_valid = 1'b0;
    fetch_if.mem_resp.Data  = '0;
    fetch_if.dec_ready      = 1'b0;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock.
  task automatic doReset();
    #2;
    rst = 1'b1;
    driveIdle();
    #1;
    checkOutput("rst_req_valid", 64'(fetch_if.mem_req_valid), 64'd0);
    checkOutput("rst_dec_valid", 64'(fetch_if.dec_valid), 64'd0);
    checkOutput("rst_dec_pc", 64'(fetch_if.dec_pc), 64'd0);
    checkOutput("rst_dec_inst", 64'(fetch_if.dec_inst.Data), 64'd0);
    mem_q.delete();
    cur_epoch    = 0;
    live         = 0;
    exp_req_addr = RESET_PC;
    exp_dec_pc   = RESET_PC;
    hold_chk     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input bit redir, input logic [31:0] target,
                               input int p_mreq, input int p_resp, input int p_dec);
    bit    resp_now;
    bit    exp_req;
    bit    req_fire;
    int    stale;
    pend_t e;
    @(posedge clk);
    #1;
    resp_now = (mem_q.size() > 0) && ($urandom_range(99) < p_resp);
    fetch_if.redirect_valid = redir;
    fetch_if.redirect_pc    = target;
    fetch_if.mem_req_ready  = ($urandom_range(99) < p_mreq);
    fetch_if.mem_resp_valid = resp_now;
    fetch_if.mem_resp.Data  = resp_now ? (mem_q[0].addr ^ DATA_KEY) : $urandom;
    fetch_if.dec_ready      = ($urandom_range(99) < p_dec);
    @(negedge clk);

    stale = 0;
    foreach (mem_q[k]) if (mem_q[k].epoch != cur_epoch) stale++;
    exp_req = !redir && (stale == 0) && (mem_q.size() < MAX_OUT) && (mem_q.size() + live < DEPTH);
    checkOutput("req_valid", 64'(fetch_if.mem_req_valid), 64'(exp_req));
    if (exp_req) checkOutput("req_addr", 64'(fetch_if.mem_req_addr), 64'(exp_req_addr));
    checkOutput("dec_valid", 64'(fetch_if.dec_valid), 64'(live > 0));
    if (hold_chk) begin
      checkOutput("hold_pc", 64'(fetch_if.dec_pc), 64'(held_pc));
      checkOutput("hold_inst", 64'(fetch_if.dec_inst.Data), 64'(held_data));
    end

    if (redir) begin
      if (resp_now) void'(mem_q.pop_front());
      cur_epoch++;
      live         = 0;
      exp_req_addr = target & ~32'h3;
      exp_dec_pc   = target & ~32'h3;
      hold_chk     = 1'b0;
    end else begin
      if (live > 0 && fetch_if.dec_ready) begin
        checkOutput("dec_pc", 64'(fetch_if.dec_pc), 64'(exp_dec_pc));
        checkOutput("dec_inst", 64'(fetch_if.dec_inst.Data), 64'(exp_dec_pc ^ DATA_KEY));
        exp_dec_pc = exp_dec_pc + 32'd4;
        live--;
        hold_chk = 1'b0;
      end else begin
        hold_chk  = (live > 0);
        held_pc   = exp_dec_pc;
        held_data = exp_dec_pc ^ DATA_KEY;
      end
      if (resp_now) begin
        e = mem_q.pop_front();
        if (e.epoch == cur_epoch) live++;
      end
      req_fire = exp_req && fetch_if.mem_req_ready;
      if (req_fire) begin
        mem_q.push_back('{addr: exp_req_addr, epoch: cur_epoch});
        exp_req_addr = exp_req_addr + 32'd4;
      end
    end
  endtask

  initial begin
    int p_m, p_r, p_d;
    driveIdle();
    doReset();

    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, '0, 100, 100, 100);
      if (i >= 4) checkOutput("no_gap", 64'(fetch_if.dec_valid), 64'd1);
    end

    doReset();
    repeat (12) applyStimulus(1'b0, '0, 100, 100, 0);
    checkOutput("full_stall", 64'(fetch_if.mem_req_valid), 64'd0);
    repeat (10) applyStimulus(1'b0, '0, 100, 100, 100);

    doReset();
    repeat (3) applyStimulus(1'b0, '0, 100, 0, 100);
    applyStimulus(1'b1, 32'h0000_0100, 100, 0, 100);
    repeat (12) applyStimulus(1'b0, '0, 100, 100, 100);

    applyStimulus(1'b1, 32'h0000_0300, 100, 100, 100);
    repeat (8) applyStimulus(1'b0, '0, 100, 100, 100);

    repeat (2) applyStimulus(1'b0, '0, 100, 0, 100);
    applyStimulus(1'b1, 32'h0000_0180, 100, 0, 100);
    applyStimulus(1'b1, 32'h0000_0202, 100, 0, 100);
    repeat (12) applyStimulus(1'b0, '0, 100, 100, 100);

    applyStimulus(1'b1, 32'hFFFF_FFF9, 100, 100, 100);
    repeat (10) applyStimulus(1'b0, '0, 100, 100, 100);

    for (int seg = 0; seg < 15; seg++) begin
      p_m = $urandom_range(100, 20);
      p_r = $urandom_range(100, 20);
      p_d = $urandom_range(100, 10);
      for (int c = 0; c < 100; c++) begin
        applyStimulus($urandom_range(99) < 4, $urandom, p_m, p_r, p_d);
      end
    end

    repeat (2) applyStimulus(1'b0, '0, 100, 0, 100);
    doReset();
    repeat (10) applyStimulus(1'b0, '0, 100, 100, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fail_count);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Front-end instruction fetcher that produces the Mem_Respond instruction stream consumed by the decode stage. It holds the PC and issues word requests to instruction memory. It tracks outstanding requests and buffers returned instructions in a small FIFO. On a branch-unit redirect it flushes the FIFO and discards stale responses.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2)
MAX_OUTSTANDING, 2, max in-flight memory requests

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
redirect_valid  input  1  branch unit redirect strobe
redirect_pc  input  32  redirect target, word aligned
mem_req_valid  output  1  fetch request valid
mem_req_addr  output  32  fetch word address
mem_req_ready  input  1  memory accepts request this cycle
mem_resp_valid  input  1  response valid; responses return in order
mem_resp  input  Mem_Respond  returned instruction; Data holds the 32-bit word
dec_valid  output  1  instruction available to decode
dec_inst  output  Mem_Respond  instruction to decode
dec_pc  output  32  PC of dec_inst
dec_ready  input  1  decode consumes the head entry

Behaviour:
- Reset (async, rst=1) sets:
  - pc=RESET_PC
  - FIFO empty
  - outstanding=0, drop_cnt=0
  - state=S_RUN
  - mem_req_valid=0, dec_valid=0, dec_inst=0, dec_pc=0
- Reset mid-operation discards all in-flight requests. The memory side is reset by the same rst.
- Issue rule in S_RUN: mem_req_valid=1 when outstanding<MAX_OUTSTANDING and fifo_count+outstanding<FIFO_DEPTH. mem_req_addr=pc, driven combinationally from the pc register.
- Request handshake:
  - A request is accepted when mem_req_valid and mem_req_ready.
  - On acceptance: pc<=pc+4 and outstanding++.
  - A push of the in-flight PC into a side PC queue pairs each response with its address.
- Response handling:
  - When mem_resp_valid and drop_cnt==0, push {mem_resp, pc_queue head} into the FIFO and decrement outstanding.
  - When drop_cnt>0, decrement outstanding and drop_cnt, pop the PC queue, and write nothing.
- Latency:
  - First request is visible in the first cycle after rst deasserts.
  - A response accepted in cycle N gives dec_valid=1 in cycle N+1 (registered FIFO output, no bypass).
- Decode handshake:
  - Head entry pops when dec_valid and dec_ready.
  - dec_inst and dec_pc stay stable while dec_valid=1 and dec_ready=0.
- Simultaneous push and pop: count unchanged. When full, the pop frees the slot for the same-cycle push. The credit rule guarantees a push never hits a full FIFO.
- Redirect (highest priority; overrides issue, push and pop in that cycle):
  - pc<=redirect_pc and the FIFO is flushed, so dec_valid=0 next cycle.
  - drop_cnt<=outstanding minus any response arriving that same cycle. That response is itself dropped.
  - A request accepted in the redirect cycle is suppressed: mem_req_valid is forced to 0 when redirect_valid=1.
  - Next state is S_FLUSH if the new drop_cnt>0, else S_RUN.
- S_FLUSH: no new requests. Return to S_RUN in the cycle after drop_cnt reaches 0.
- Redirect while in S_FLUSH: pc is reloaded and drop_cnt is recomputed the same way (cumulative stale count).
- pc wraps modulo 2^32. Bits [1:0] are always 0; redirect_pc[1:0] is ignored.
- mem_resp_valid with outstanding==0 is a protocol error. It is ignored, and an assertion flags it in simulation.

Decomposition:
- Shared package (System_Pkg) holds:
  - Mem_Respond (existing)
  - new typedef Fetch_Entry {Mem_Respond inst; logic [31:0] pc;}
  - fetch FSM state enum {S_RUN, S_FLUSH}
  - RESET_PC default constant
- One sub-module: fetch_fifo. It is a generic synchronous FIFO parameterised by depth and entry type, with flush, push, pop, count, full and empty. It is instantiated twice: once for the instruction buffer and once for the PC queue (depth MAX_OUTSTANDING).

Test Plan:
- Reset, mem_req_ready=1, 1-cycle memory returning Data=addr ^ 32'hA5A5_0000, dec_ready=1 → requests 0x0,0x4,0x8…; dec_pc/dec_inst pairs match in order; no gaps after warm-up.
- dec_ready=0 held → at most FIFO_DEPTH (4) entries buffered; mem_req_valid drops once fifo_count+outstanding=4; releasing dec_ready drains entries 0x0..0xC unchanged.
- Two requests outstanding (0x10, 0x14), then redirect_pc=0x100 → both responses dropped; state S_FLUSH for 2 responses; next request addr=0x100; first dec_pc=0x100.
- Redirect in the same cycle as a response and a dec pop → FIFO empty next cycle; that response dropped; drop_cnt=outstanding-1.
- Second redirect (0x200) during S_FLUSH → stale responses from both epochs dropped; first dec_pc=0x200.
- rst asserted asynchronously mid-stream with 2 outstanding → outputs zero immediately; after release, fetch restarts at RESET_PC with outstanding=0.
